xnor_stream_comparator: RTL and testbench

- Bit-serial word comparator. Consumes two bit streams A/B, one pair per accepted beat, and evaluates each pair through a 2-input XNOR equality cell.
- Accumulates per-frame results over WORD_LEN bits: equal flag, mismatch count, index of first mismatch.
- Sits directly downstream of the XNOR gate stage and turns per-bit equality into a registered, handshaked word-level verdict.

---
 rtl/xnor_cmp_pkg.sv | 20 ++
 rtl/xnor_bit.sv | 10 +
 rtl/xnor_stream_comparator.sv | 125 ++++++++++++
 tb/tb_xnor_stream_comparator.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/xnor_cmp_pkg.sv
// Shared types and width helpers for the bit-serial XNOR word comparator.
// Both the top level and the bench import this package.
package xnor_cmp_pkg;

  typedef enum logic {ACCUM, HOLD} cmp_state_t;

  // Ceiling log2, usable in parameter defaults; returns 0 for value <= 1.
  function automatic int cmp_clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/xnor_bit.sv
// Single 2-input XNOR equality cell: y is 1 when a and b agree (00 or 11).
module xnor_bit (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a ^ b);

endmodule

// File: rtl/xnor_stream_comparator.sv
// Bit-serial word comparator: accumulates per-beat XNOR matches over a frame
// of WORD_LEN pairs and presents a handshaked equal/count/first-index verdict.
module xnor_stream_comparator
  import xnor_cmp_pkg::*;
#(
  parameter int WORD_LEN = 8,
  parameter int CNT_W    = cmp_clog2(WORD_LEN + 1),
  parameter int IDX_W    = cmp_clog2(WORD_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_equal,
  output logic [CNT_W-1:0] res_mismatch_cnt,
  output logic [IDX_W-1:0] res_first_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  cmp_state_t       state_q;
  cmp_state_t       state_d;
  logic [IDX_W-1:0] bit_idx;
  logic [CNT_W-1:0] acc_cnt;
  logic [IDX_W-1:0] acc_first;
  logic             seen;
  logic             match;
  logic             accept;
  logic             last_beat;
  logic [CNT_W-1:0] final_cnt;
  logic [IDX_W-1:0] final_first;

  xnor_bit u_match (
    .a (in_a),
    .b (in_b),
    .y (match)
  );

  // A pair presented together with clear is dropped, even though in_ready is high.
  always_comb begin
    in_ready    = (state_q == ACCUM);
    res_valid   = (state_q == HOLD);
    accept      = in_valid && in_ready && !clear;
    last_beat   = (bit_idx == LAST_IDX);
    final_cnt   = match ? acc_cnt : (acc_cnt + CNT_ONE);
    final_first = '0;
    if (seen) begin
      final_first = acc_first;
    end else if (!match) begin
      final_first = bit_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM: begin
        if (accept && last_beat) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (clear || res_ready) begin
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Accumulators restart on the last beat so the next frame begins clean.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      bit_idx   <= '0;
      acc_cnt   <= '0;
      acc_first <= '0;
      seen      <= 1'b0;
    end else if (accept) begin
      if (last_beat) begin
        bit_idx   <= '0;
        acc_cnt   <= '0;
        acc_first <= '0;
        seen      <= 1'b0;
      end else begin
        bit_idx <= bit_idx + IDX_ONE;
        if (!match) begin
          acc_cnt <= acc_cnt + CNT_ONE;
          if (!seen) begin
            acc_first <= bit_idx;
            seen      <= 1'b1;
          end
        end
      end
    end
  end

  // Result data is only written on a completed frame and otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_equal        <= 1'b0;
      res_mismatch_cnt <= '0;
      res_first_idx    <= '0;
    end else if (accept && last_beat) begin
      res_equal        <= (final_cnt == '0);
      res_mismatch_cnt <= final_cnt;
      res_first_idx    <= final_first;
    end
  end

endmodule

// File: tb/tb_xnor_stream_comparator.sv
// Directed self-checking bench for xnor_stream_comparator (WORD_LEN = 8),
// frames sent LSB first with hand-computed verdicts.
module tb_xnor_stream_comparator;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic       in_a;
  logic       in_b;
  logic       res_valid;
  logic       res_ready;
  logic       res_equal;
  logic [3:0] res_mismatch_cnt;
  logic [2:0] res_first_idx;

  int checks;
  int failures;

  xnor_stream_comparator #(.WORD_LEN(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .clear            (clear),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_equal        (res_equal),
    .res_mismatch_cnt (res_mismatch_cnt),
    .res_first_idx    (res_first_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one pair and waits (bounded) until it is taken.
  task automatic applyStimulus(input logic a, input logic b);
    int waited;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) checkOutput("ready_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [7:0] a_word, input logic [7:0] b_word,
                           input int max_gap, input string tag);
    int gap;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) checkOutput({tag, "_not_early"}, {31'd0, res_valid}, 32'd0);
      applyStimulus(a_word[i], b_word[i]);
      if (i < 7 && max_gap > 0) begin
        gap = $urandom_range(0, max_gap);
        for (int g = 0; g < gap; g++) tick();
      end
    end
  endtask

  // Called one cycle after the last accept: checks verdict, then handshakes.
  task automatic collectResult(input logic exp_equal, input logic [3:0] exp_cnt,
                               input logic [2:0] exp_idx, input string tag);
    checkOutput({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    checkOutput({tag, "_equal"}, {31'd0, res_equal}, {31'd0, exp_equal});
    checkOutput({tag, "_cnt"}, {28'd0, res_mismatch_cnt}, {28'd0, exp_cnt});
    checkOutput({tag, "_idx"}, {29'd0, res_first_idx}, {29'd0, exp_idx});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
    checkOutput({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_cnt_kept"}, {28'd0, res_mismatch_cnt}, {28'd0, exp_cnt});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 1'b0;
    in_b      = 1'b1;
    res_ready = 1'b0;

    // Reset with a mismatching pair offered; none of it may be counted.
    tick();
    tick();
    checkOutput("rst_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_equal", {31'd0, res_equal}, 32'd0);
    checkOutput("rst_cnt", {28'd0, res_mismatch_cnt}, 32'd0);
    checkOutput("rst_idx", {29'd0, res_first_idx}, 32'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    checkOutput("rst_ready", {31'd0, in_ready}, 32'd1);

    $display("[TB] equal frame");
    sendFrame(8'hA6, 8'hA6, 0, "eq");
    collectResult(1'b1, 4'd0, 3'd0, "eq");

    $display("[TB] mismatch frames");
    sendFrame(8'hFF, 8'h00, 0, "all_mis");
    collectResult(1'b0, 4'd8, 3'd0, "all_mis");
    sendFrame(8'h00, 8'h80, 0, "last_mis");
    collectResult(1'b0, 4'd1, 3'd7, "last_mis");

    $display("[TB] backpressure");
    sendFrame(8'h0F, 8'h0E, 0, "bp1");
    in_valid = 1'b1;
    in_a     = 1'b0;
    in_b     = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_hold_valid", {31'd0, res_valid}, 32'd1);
      checkOutput("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_hold_cnt", {28'd0, res_mismatch_cnt}, 32'd1);
      checkOutput("bp_hold_idx", {29'd0, res_first_idx}, 32'd0);
      tick();
    end
    collectResult(1'b0, 4'd1, 3'd0, "bp1");
    sendFrame(8'h3C, 8'h5A, 0, "bp2");
    collectResult(1'b0, 4'd4, 3'd1, "bp2");

    $display("[TB] bubbles");
    sendFrame(8'h00, 8'h80, 3, "bubble");
    collectResult(1'b0, 4'd1, 3'd7, "bubble");

    $display("[TB] abort with clear");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_a     = 1'b1;
    in_b     = 1'b0;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    checkOutput("clr_ready", {31'd0, in_ready}, 32'd1);
    sendFrame(8'hC3, 8'hC3, 0, "clr");
    collectResult(1'b1, 4'd0, 3'd0, "clr");

    $display("[TB] abort with reset");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_a     = 1'b1;
    in_b     = 1'b0;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    checkOutput("rstab_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rstab_ready", {31'd0, in_ready}, 32'd1);
    sendFrame(8'h5A, 8'h5A, 0, "rstab");
    collectResult(1'b1, 4'd0, 3'd0, "rstab");

    $display("[TB] clear during hold");
    sendFrame(8'h01, 8'h03, 0, "hclr");
    checkOutput("hclr_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("hclr_idx", {29'd0, res_first_idx}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("hclr_valid_drop", {31'd0, res_valid}, 32'd0);
    checkOutput("hclr_ready", {31'd0, in_ready}, 32'd1);
    sendFrame(8'h33, 8'h13, 0, "after_hclr");
    collectResult(1'b0, 4'd1, 3'd5, "after_hclr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
